// File: rtl/fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl_if
// Description : Handshake and status bundle between the producer/consumer
//               logic (master) and the FIFO pointer/flag controller (slave).
//               Carries push/pop/err_clr requests toward the controller and
//               RAM addressing, write enable and FIFO status back out.
// Parameters  : AW - RAM address width (count is AW+1 bits wide)
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_ctrl_if #(
  parameter int AW = 2
) ();

  logic          push;
  logic          pop;
  logic          err_clr;
  logic [AW-1:0] wadr;
  logic [AW-1:0] radr;
  logic          wr;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  modport master (
    output push, pop, err_clr,
    input  wadr, radr, wr, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  push, pop, err_clr,
    output wadr, radr, wr, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl
// Description : Pointer and flag controller sequencing a simple dual-port RAM
//               (combinational read) as a first-word fall-through FIFO.
//               Drives RAM write/read addresses and write enable; publishes
//               full/empty, occupancy, almost-full/almost-empty thresholds and
//               sticky overflow/underflow flags.
// Ports       : clk      - clock, all state on posedge
//               rst_n    - synchronous active-low reset
//               bus      - fifo_ctrl_if.slave: push, pop, err_clr in;
//                          wadr, radr, wr, full, empty, almost_full,
//                          almost_empty, count, overflow, underflow out
// Options     : FIFO_CTRL_ERR_EN - when defined, compiles in the sticky
//               overflow/underflow flags and err_clr; otherwise both flags
//               are tied low and err_clr is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl #(
  parameter int AW        = 2,
  parameter int DEPTH     = 1 << AW,
  parameter int AFULL_TH  = 3,
  parameter int AEMPTY_TH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  fifo_ctrl_if.slave  bus
);

  localparam logic [AW:0] c_DEPTH     = DEPTH[AW:0];
  localparam logic [AW:0] c_AFULL_TH  = AFULL_TH[AW:0];
  localparam logic [AW:0] c_AEMPTY_TH = AEMPTY_TH[AW:0];
  localparam logic [AW:0] c_ZERO      = '0;

  // Pointers carry one extra MSB so full and empty remain distinguishable
  // when the address bits coincide; they wrap naturally modulo 2*DEPTH.
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [AW:0] r_count;
  logic        r_full;
  logic        r_empty;
  logic        r_almost_full;
  logic        r_almost_empty;

  logic        w_push_ok;
  logic        w_pop_ok;
  logic [AW:0] w_count_nxt;

  // A push into a full FIFO is still legal when the head is popped in the
  // same cycle: the write lands on the slot being vacated.
  assign w_push_ok   = bus.push & (~r_full | bus.pop);
  assign w_pop_ok    = bus.pop & ~r_empty;
  assign w_count_nxt = r_count + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop_ok};

  // Status flags are registered from the next-state count so they never
  // have a combinational path from push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_wptr         <= r_wptr + {{AW{1'b0}}, w_push_ok};
      r_rptr         <= r_rptr + {{AW{1'b0}}, w_pop_ok};
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == c_DEPTH);
      r_empty        <= (w_count_nxt == c_ZERO);
      r_almost_full  <= (w_count_nxt >= c_AFULL_TH);
      r_almost_empty <= (w_count_nxt <= c_AEMPTY_TH);
    end
  end

  // RAM captures din on the same edge the write pointer advances.
  assign bus.wr           = rst_n & w_push_ok;
  assign bus.wadr         = r_wptr[AW-1:0];
  assign bus.radr         = r_rptr[AW-1:0];
  assign bus.count        = r_count;
  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_almost_full;
  assign bus.almost_empty = r_almost_empty;

`ifdef FIFO_CTRL_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags; a new error in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (bus.push & r_full & ~bus.pop) | (r_overflow & ~bus.err_clr);
      r_underflow <= (bus.pop & r_empty) | (r_underflow & ~bus.err_clr);
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`else
  // Rejected requests are silently dropped; err_clr has no function here.
  logic w_unused_err_clr;
  assign w_unused_err_clr = bus.err_clr;

  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_ctrl
// Description : Directed self-checking bench for fifo_ctrl with a small
//               combinational-read RAM model attached to its address/enable
//               outputs. Expected error-flag values follow FIFO_CTRL_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

`ifdef FIFO_CTRL_ERR_EN
  localparam logic c_ERR = 1'b1;
`else
  localparam logic c_ERR = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic [7:0] dout;
  logic [7:0] mem [4];
  logic [7:0] q [$];
  logic [7:0] exp_seq [4];

  int n_checks = 0;
  int n_fail   = 0;

  fifo_ctrl_if #(.AW(2)) bus ();

  fifo_ctrl #(
    .AW(2), .DEPTH(4), .AFULL_TH(3), .AEMPTY_TH(1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous write, combinational read.
  always @(posedge clk) begin
    if (bus.wr) mem[bus.wadr] <= din;
  end
  assign dout = mem[bus.radr];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic p, input logic r, input logic [7:0] d, input logic c);
    bus.push    = p;
    bus.pop     = r;
    din         = d;
    bus.err_clr = c;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 8'h55, 1'b0);
    check_eq("rst_wr_forced0", 32'(bus.wr), 32'd0);
    tick;
    tick;
    check_eq("rst_wr_forced0_b", 32'(bus.wr), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check_eq("rst_count", 32'(bus.count), 32'd0);
    check_eq("rst_empty", 32'(bus.empty), 32'd1);
    check_eq("rst_full", 32'(bus.full), 32'd0);
    check_eq("rst_aempty", 32'(bus.almost_empty), 32'd1);
    check_eq("rst_afull", 32'(bus.almost_full), 32'd0);
    check_eq("rst_radr", 32'(bus.radr), 32'd0);
    check_eq("rst_wadr", 32'(bus.wadr), 32'd0);
    check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
    check_eq("rst_unf", 32'(bus.underflow), 32'd0);
    rst_n = 1'b1;
    tick;
    check_eq("idle_wr", 32'(bus.wr), 32'd0);
    check_eq("idle_empty", 32'(bus.empty), 32'd1);

    // Fill with A0..A3.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
      check_eq("fill_wr", 32'(bus.wr), 32'd1);
      check_eq("fill_wadr", 32'(bus.wadr), 32'(i));
      tick;
      check_eq("fill_count", 32'(bus.count), 32'(i + 1));
      check_eq("fill_empty", 32'(bus.empty), 32'd0);
      check_eq("fill_afull", 32'(bus.almost_full), (i >= 2) ? 32'd1 : 32'd0);
      check_eq("fill_aempty", 32'(bus.almost_empty), (i == 0) ? 32'd1 : 32'd0);
      check_eq("fill_full", 32'(bus.full), (i == 3) ? 32'd1 : 32'd0);
      check_eq("fill_head", 32'(dout), 32'hA0);
    end

    // Push alone while full: rejected.
    drive(1'b1, 1'b0, 8'hEE, 1'b0);
    check_eq("ovf_wr", 32'(bus.wr), 32'd0);
    tick;
    check_eq("ovf_count", 32'(bus.count), 32'd4);
    check_eq("ovf_flag", 32'(bus.overflow), 32'(c_ERR));
    check_eq("ovf_wadr", 32'(bus.wadr), 32'd0);

    // Drain.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      check_eq("drain_dout", 32'(dout), 32'(8'hA0 + i));
      tick;
      check_eq("drain_count", 32'(bus.count), 32'(3 - i));
      check_eq("drain_full", 32'(bus.full), 32'd0);
      check_eq("drain_empty", 32'(bus.empty), (i == 3) ? 32'd1 : 32'd0);
    end

    // Pop while empty: rejected, pointer unchanged.
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    tick;
    check_eq("unf_flag", 32'(bus.underflow), 32'(c_ERR));
    check_eq("unf_radr", 32'(bus.radr), 32'd0);
    check_eq("unf_count", 32'(bus.count), 32'd0);
    check_eq("unf_ovf_sticky", 32'(bus.overflow), 32'(c_ERR));

    drive(1'b0, 1'b0, 8'h00, 1'b1);
    tick;
    check_eq("clr_ovf", 32'(bus.overflow), 32'd0);
    check_eq("clr_unf", 32'(bus.underflow), 32'd0);

    // Refill, then simultaneous push+pop while full.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
      tick;
    end
    check_eq("refill_full", 32'(bus.full), 32'd1);
    drive(1'b1, 1'b1, 8'hB0, 1'b0);
    check_eq("fpp_dout", 32'(dout), 32'hA0);
    check_eq("fpp_wr", 32'(bus.wr), 32'd1);
    check_eq("fpp_wadr", 32'(bus.wadr), 32'd0);
    tick;
    check_eq("fpp_count", 32'(bus.count), 32'd4);
    check_eq("fpp_full", 32'(bus.full), 32'd1);
    check_eq("fpp_ovf", 32'(bus.overflow), 32'd0);
    check_eq("fpp_wadr_next", 32'(bus.wadr), 32'd1);
    exp_seq[0] = 8'hA1; exp_seq[1] = 8'hA2; exp_seq[2] = 8'hA3; exp_seq[3] = 8'hB0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      check_eq("fpp_drain_dout", 32'(dout), 32'(exp_seq[i]));
      tick;
    end
    check_eq("fpp_drain_empty", 32'(bus.empty), 32'd1);

    // Simultaneous push+pop while empty.
    drive(1'b1, 1'b1, 8'hC5, 1'b0);
    check_eq("epp_wr", 32'(bus.wr), 32'd1);
    tick;
    check_eq("epp_count", 32'(bus.count), 32'd1);
    check_eq("epp_unf", 32'(bus.underflow), 32'(c_ERR));
    check_eq("epp_empty", 32'(bus.empty), 32'd0);
    check_eq("epp_dout", 32'(dout), 32'hC5);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    tick;
    check_eq("epp_clr_unf", 32'(bus.underflow), 32'd0);

    // Soak: alternating pop/push from count 2, pointers wrap.
    drive(1'b1, 1'b0, 8'hD0, 1'b0);
    tick;
    check_eq("soak_start_count", 32'(bus.count), 32'd2);
    q.push_back(8'hC5);
    q.push_back(8'hD0);
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        check_eq("soak_dout", 32'(dout), 32'(q[0]));
        tick;
        void'(q.pop_front());
      end else begin
        drive(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        tick;
        q.push_back(8'(8'h40 + i));
      end
      check_eq("soak_count", 32'(bus.count), 32'(q.size()));
    end
    check_eq("soak_head", 32'(dout), 32'(q[0]));

    // Reset in the middle of traffic discards contents.
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 8'h99, 1'b0);
    tick;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check_eq("mrst_count", 32'(bus.count), 32'd0);
    check_eq("mrst_empty", 32'(bus.empty), 32'd1);
    check_eq("mrst_radr", 32'(bus.radr), 32'd0);
    check_eq("mrst_wadr", 32'(bus.wadr), 32'd0);
    drive(1'b1, 1'b0, 8'h77, 1'b0);
    tick;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check_eq("mrst_push_count", 32'(bus.count), 32'd1);
    check_eq("mrst_push_dout", 32'(dout), 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller that sequences the simple dual-port RAM as a synchronous FIFO. It accepts push/pop requests, drives the RAM's write address, read address and write enable, and publishes full, empty, occupancy and almost-full/almost-empty status. The RAM read path is combinational on the read address, so the head word is visible on the RAM output whenever the FIFO is not empty (first-word fall-through). It sits between the producer/consumer handshake logic and one `ram` instance with matching `AW`/`DEPTH`.

## Interface
- `AW`, 2: address width; must match the RAM instance.
- `DEPTH`, 4: entries; fixed at 2^AW.
- `AFULL_TH`, 3: `almost_full` asserts when count >= AFULL_TH.
- `AEMPTY_TH`, 1: `almost_empty` asserts when count <= AEMPTY_TH.

- `clk`  in  1: clock, all state on posedge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `push`  in  1: producer requests write of the current RAM `din` this cycle.
- `pop`  in  1: consumer has taken the head word this cycle.
- `err_clr`  in  1: clears sticky error flags.
- `wadr`  out  AW: RAM write address.
- `radr`  out  AW: RAM read address (head of FIFO).
- `wr`  out  1: RAM write enable.
- `full`  out  1: count == DEPTH.
- `empty`  out  1: count == 0.
- `almost_full`  out  1: threshold status.
- `almost_empty`  out  1: threshold status.
- `count`  out  AW+1: occupancy, 0..DEPTH.
- `overflow`  out  1: sticky, push attempted while full and not accepted.
- `underflow`  out  1: sticky, pop attempted while empty.

## Operation
- Internal `wptr`, `rptr` are AW+1 bits; `wadr`=wptr[AW-1:0], `radr`=rptr[AW-1:0]; MSB distinguishes full from empty. Pointers wrap modulo 2·DEPTH with natural overflow.
- Accept rules, evaluated on current (pre-edge) state:
  - push_ok = push & (~full | pop); pop_ok = pop & ~empty.
  - Full with push+pop: both accepted; the write lands on the slot being vacated, legal because the head was consumed combinationally before the edge. Count stays DEPTH.
  - Empty with push+pop: push accepted, pop rejected, underflow set. Count becomes 1.
- `wr` = push_ok (combinational), so the RAM captures `din` on the same edge the pointer advances.
- On edge: wptr += push_ok; rptr += pop_ok; count += push_ok − pop_ok.
- `full`, `empty`, `almost_*` are registered, computed from next-state count; never derived from `push`/`pop` combinationally.
- Errors: overflow sets on push & full & ~pop; underflow sets on pop & empty. Both hold until `err_clr`. If `err_clr` and a new error fall in the same cycle, set wins.
- No state machine beyond pointers/count; behaviour is fully defined by the rules above.

## Timing
- Reset (rst_n low at posedge): wptr=rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=underflow=0. `wr` is forced 0 while rst_n is low. Reset mid-traffic discards contents; stored RAM words are not cleared.
- Push latency: word written at edge N; `empty` falls and the word is visible on RAM `dout` after edge N (cycle N+1).
- Pop: the head is valid in the same cycle `pop` is asserted; `radr` advances after the edge.
- Status outputs change only on posedge; one-cycle update after the accepted operation.

## Configuration
- `FIFO_CTRL_ERR_EN`: defined → `overflow`/`underflow` sticky logic and `err_clr` handling are compiled in as described. Undefined → both outputs are tied 0, `err_clr` is ignored; accept rules are unchanged (rejected requests are silently dropped).

## Test plan
- Reset then idle: after rst_n low 2 cycles → count=0, empty=1, full=0, wr=0, radr=wadr=0.
- Fill DEPTH=4 with din 0xA0..0xA3 → full=1 after 4th edge, count=4, almost_full=1 after 3rd; 5th push alone → wr=0, overflow=1 (with FIFO_CTRL_ERR_EN).
- Drain 4 pops → dout sequence 0xA0,0xA1,0xA2,0xA3, empty=1 after 4th; extra pop → underflow=1, rptr unchanged.
- Full, push 0xB0 + pop same cycle → dout showed 0xA0, count stays 4, wadr wrapped to 0; subsequent drain yields 0xA1,0xA2,0xA3,0xB0.
- Empty, push 0xC5 + pop same cycle → count=1, underflow=1, next cycle dout=0xC5; err_clr → underflow=0.
- Wrap soak: 20 cycles of alternating push/pop from count=2 → pointers wrap past 7, count stays 1..2, data order preserved; rst_n pulsed mid-sequence → count=0, empty=1 next cycle.
